// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pipe_pkg -- shared constants and types for the control pipeline.
//
// Control word layout (CTRL_WIDTH = 17), packed {Ex, Mem, Wb}:
//   [16]    JumpLink
//   [15:13] BranchOperation
//   [12:9]  AluOperation
//   [8:7]   AluSourceSelector
//   [6:4]   MemoryOperation
//   [3]     MemWriteEn
//   [2]     MemReadEn
//   [1]     RegWriteEn
//   [0]     Mem2Reg
// The EX stage carries the whole word. MEM carries {Mem, Wb}. WB carries {Wb}.
package ctrl_pipe_pkg;

  localparam int EX_FIELD_WIDTH  = 10;
  localparam int MEM_FIELD_WIDTH = 5;
  localparam int WB_FIELD_WIDTH  = 2;

  localparam int CTRL_WIDTH     = EX_FIELD_WIDTH + MEM_FIELD_WIDTH + WB_FIELD_WIDTH;
  localparam int EX_CTRL_WIDTH  = CTRL_WIDTH;
  localparam int MEM_CTRL_WIDTH = MEM_FIELD_WIDTH + WB_FIELD_WIDTH;
  localparam int WB_CTRL_WIDTH  = WB_FIELD_WIDTH;

  localparam int BRANCH_OP_W = 3;
  localparam int ALU_OP_W    = 4;
  localparam int ALU_SRC_W   = 2;
  localparam int MEM_OP_W    = 3;

  localparam int OFF_JUMP_LINK = 16;
  localparam int OFF_BRANCH_OP = 13;
  localparam int OFF_ALU_OP    = 9;
  localparam int OFF_ALU_SRC   = 7;
  localparam int OFF_MEM_OP    = 4;
  localparam int OFF_MEM_WRITE = 3;
  localparam int OFF_MEM_READ  = 2;
  localparam int OFF_REG_WRITE = 1;
  localparam int OFF_MEM2REG   = 0;

  // Branch unit "no operation" code. It is non-zero, so a bubble is not all-zero.
  localparam logic [BRANCH_OP_W-1:0] BRU_NOP = 3'b010;

  typedef logic [CTRL_WIDTH-1:0] ctrl_word_t;

  typedef struct packed {
    logic                  valid;
    logic [CTRL_WIDTH-1:0] ctrl;
    logic [4:0]            rd;
  } ctrl_stage_t;

  typedef struct packed {
    logic                      valid;
    logic [MEM_CTRL_WIDTH-1:0] ctrl;
    logic [4:0]                rd;
  } mem_stage_t;

  typedef struct packed {
    logic                     valid;
    logic [WB_CTRL_WIDTH-1:0] ctrl;
    logic [4:0]               rd;
  } wb_stage_t;

  localparam ctrl_word_t  BUBBLE_CTRL = CTRL_WIDTH'(BRU_NOP) << OFF_BRANCH_OP;
  localparam ctrl_stage_t CTRL_BUBBLE = '{valid: 1'b0, ctrl: BUBBLE_CTRL, rd: 5'd0};
  localparam mem_stage_t  MEM_BUBBLE  = '{valid: 1'b0, ctrl: BUBBLE_CTRL[MEM_CTRL_WIDTH-1:0], rd: 5'd0};
  localparam wb_stage_t   WB_BUBBLE   = '{valid: 1'b0, ctrl: BUBBLE_CTRL[WB_CTRL_WIDTH-1:0], rd: 5'd0};

  // Register x0 is hard-wired to zero, so it never becomes a write target.
  function automatic ctrl_word_t strip_x0_write(ctrl_word_t c, logic [4:0] rd);
    ctrl_word_t r;
    r = c;
    if (rd == 5'd0) r[OFF_REG_WRITE] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/ctrl_pipe_if.sv
// ctrl_pipe_if -- ID-stage handshake bus into the control pipeline.
//   IdValid  : decode holds a valid control word
//   IdCtrl   : decoder control word {Ex, Mem, Wb}
//   IdRd     : destination register index
//   IdRs1/2  : source register indices
//   IdReady  : the word is consumed this cycle (driven by the pipeline)
interface ctrl_pipe_if;
  import ctrl_pipe_pkg::*;

  logic                  IdValid;
  logic [CTRL_WIDTH-1:0] IdCtrl;
  logic [4:0]            IdRd;
  logic [4:0]            IdRs1;
  logic [4:0]            IdRs2;
  logic                  IdReady;

  modport master (output IdValid, IdCtrl, IdRd, IdRs1, IdRs2, input IdReady);
  modport slave  (input IdValid, IdCtrl, IdRd, IdRs1, IdRs2, output IdReady);
endinterface

// File: rtl/ctrl_hazard_unit.sv
// ctrl_hazard_unit -- load-use hazard comparator (combinational).
//   id_valid / id_rs1 / id_rs2 : instruction waiting in ID
//   ex_valid / ex_mem_read / ex_rd : instruction currently in EX
//   flush    : the ID word is being discarded, so it cannot cause a hazard
//   load_use : the ID word needs a load result that is not available yet
module ctrl_hazard_unit (
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       flush,
  output logic       load_use
);
  logic src_match;

  assign src_match = (ex_rd == id_rs1) || (ex_rd == id_rs2);
  assign load_use  = id_valid && ex_valid && ex_mem_read && (ex_rd != 5'd0)
                     && src_match && !flush;
endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe -- EX/MEM/WB control-word pipeline with load-use interlock.
//   clk, rst_n       : clock and synchronous active-low reset
//   id_if            : ID-stage handshake (slave side)
//   StallIn          : freezes every stage and RetireCount
//   Flush            : a taken branch or jump drops the ID word
//   Ex*/Mem*/Wb*     : registered stage contents {ctrl, valid, rd}
//   LoadUseStall     : a bubble is inserted for a load-use hazard (combinational)
//   RetireCount      : number of valid words that have left WB (wraps)
// Optional feature: define CTRL_PIPE_HAZARD_EN to build load-use detection.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  ctrl_pipe_if.slave                id_if,
  input  logic                      StallIn,
  input  logic                      Flush,
  output logic [EX_CTRL_WIDTH-1:0]  ExCtrl,
  output logic                      ExValid,
  output logic [4:0]                ExRd,
  output logic [MEM_CTRL_WIDTH-1:0] MemCtrl,
  output logic                      MemValid,
  output logic [4:0]                MemRd,
  output logic [WB_CTRL_WIDTH-1:0]  WbCtrl,
  output logic                      WbValid,
  output logic [4:0]                WbRd,
  output logic                      LoadUseStall,
  output logic [31:0]               RetireCount
);
  ctrl_stage_t ex_q, ex_d;
  mem_stage_t  mem_q, mem_d;
  wb_stage_t   wb_q, wb_d;
  logic [31:0] retire_q, retire_d;
  logic        advance;
  logic        hazard;
  logic        id_ready;
  logic        id_take;

  assign advance = ~StallIn;

`ifdef CTRL_PIPE_HAZARD_EN
  ctrl_hazard_unit u_hazard (
    .id_valid   (id_if.IdValid),
    .id_rs1     (id_if.IdRs1),
    .id_rs2     (id_if.IdRs2),
    .ex_valid   (ex_q.valid),
    .ex_mem_read(ex_q.ctrl[OFF_MEM_READ]),
    .ex_rd      (ex_q.rd),
    .flush      (Flush),
    .load_use   (hazard)
  );
`else
  // Source indices only matter to the hazard comparator.
  logic unused_rs;
  assign unused_rs = ^{id_if.IdRs1, id_if.IdRs2};
  assign hazard    = 1'b0;
`endif

  // Both handshake outputs are gated by reset so they read 0 during reset.
  assign id_ready     = rst_n && id_if.IdValid && advance && !hazard;
  assign LoadUseStall = rst_n && hazard;
  assign id_if.IdReady = id_ready;
  // A flushed word is still consumed (IdReady=1) but is not allowed into EX.
  assign id_take      = id_ready && !Flush;

  always_comb begin
    ex_d     = ex_q;
    mem_d    = mem_q;
    wb_d     = wb_q;
    retire_d = retire_q;
    if (advance) begin
      if (wb_q.valid) retire_d = retire_q + 32'd1;
      wb_d.valid  = mem_q.valid;
      wb_d.ctrl   = mem_q.ctrl[WB_CTRL_WIDTH-1:0];
      wb_d.rd     = mem_q.rd;
      mem_d.valid = ex_q.valid;
      mem_d.ctrl  = ex_q.ctrl[MEM_CTRL_WIDTH-1:0];
      mem_d.rd    = ex_q.rd;
      if (id_take) begin
        ex_d.valid = 1'b1;
        ex_d.ctrl  = strip_x0_write(id_if.IdCtrl, id_if.IdRd);
        ex_d.rd    = id_if.IdRd;
      end else begin
        ex_d = CTRL_BUBBLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q     <= CTRL_BUBBLE;
      mem_q    <= MEM_BUBBLE;
      wb_q     <= WB_BUBBLE;
      retire_q <= 32'd0;
    end else begin
      ex_q     <= ex_d;
      mem_q    <= mem_d;
      wb_q     <= wb_d;
      retire_q <= retire_d;
    end
  end

  assign ExCtrl      = ex_q.ctrl;
  assign ExValid     = ex_q.valid;
  assign ExRd        = ex_q.rd;
  assign MemCtrl     = mem_q.ctrl;
  assign MemValid    = mem_q.valid;
  assign MemRd       = mem_q.rd;
  assign WbCtrl      = wb_q.ctrl;
  assign WbValid     = wb_q.valid;
  assign WbRd        = wb_q.rd;
  assign RetireCount = retire_q;
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe -- self-checking bench for ctrl_pipe: directed scenarios
// followed by randomized traffic, all checked against a slot-list model.
module tb_ctrl_pipe;
  import ctrl_pipe_pkg::*;

`ifdef CTRL_PIPE_HAZARD_EN
  localparam bit HAZ = 1'b1;
`else
  localparam bit HAZ = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic StallIn = 1'b0;
  logic Flush = 1'b0;
  logic [EX_CTRL_WIDTH-1:0]  ExCtrl;
  logic                      ExValid;
  logic [4:0]                ExRd;
  logic [MEM_CTRL_WIDTH-1:0] MemCtrl;
  logic                      MemValid;
  logic [4:0]                MemRd;
  logic [WB_CTRL_WIDTH-1:0]  WbCtrl;
  logic                      WbValid;
  logic [4:0]                WbRd;
  logic                      LoadUseStall;
  logic [31:0]               RetireCount;

  ctrl_pipe_if id_if();

  ctrl_pipe dut (
    .clk(clk), .rst_n(rst_n), .id_if(id_if), .StallIn(StallIn), .Flush(Flush),
    .ExCtrl(ExCtrl), .ExValid(ExValid), .ExRd(ExRd),
    .MemCtrl(MemCtrl), .MemValid(MemValid), .MemRd(MemRd),
    .WbCtrl(WbCtrl), .WbValid(WbValid), .WbRd(WbRd),
    .LoadUseStall(LoadUseStall), .RetireCount(RetireCount)
  );

  always #5 clk = ~clk;

  // Model: slot 0 = EX, 1 = MEM, 2 = WB; each slot keeps the full word.
  bit                    m_valid [3];
  logic [CTRL_WIDTH-1:0] m_ctrl  [3];
  logic [4:0]            m_rd    [3];
  logic [31:0]           m_retire;
  bit                    m_last_rdy;
  int                    n_checks = 0;
  int                    n_pass = 0;
  int                    cyc = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
  endtask

  function automatic logic [CTRL_WIDTH-1:0] bubble_word();
    logic [CTRL_WIDTH-1:0] c;
    c = '0;
    c[OFF_BRANCH_OP +: BRANCH_OP_W] = BRU_NOP;
    return c;
  endfunction

  function automatic logic [CTRL_WIDTH-1:0] mk_ctrl(bit regw, bit memrd, bit memwr,
                                                    logic [2:0] br, logic [3:0] alu, bit jl);
    logic [CTRL_WIDTH-1:0] c;
    c = '0;
    c[OFF_JUMP_LINK] = jl;
    c[OFF_BRANCH_OP +: BRANCH_OP_W] = br;
    c[OFF_ALU_OP +: ALU_OP_W] = alu;
    c[OFF_MEM_READ] = memrd;
    c[OFF_MEM_WRITE] = memwr;
    c[OFF_REG_WRITE] = regw;
    c[OFF_MEM2REG] = memrd;
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_valid[i] = 1'b0;
      m_ctrl[i]  = bubble_word();
      m_rd[i]    = 5'd0;
    end
    m_retire = 32'd0;
  endtask

  task automatic drive(input bit v, input logic [CTRL_WIDTH-1:0] c, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    id_if.IdValid = v;
    id_if.IdCtrl  = c;
    id_if.IdRd    = rd;
    id_if.IdRs1   = rs1;
    id_if.IdRs2   = rs2;
  endtask

  // One clock: check handshake, advance the model, then check stage registers.
  task automatic cycle();
    bit lus, rdy;
    logic [CTRL_WIDTH-1:0] w;
    #1;
    lus = 1'b0;
    rdy = 1'b0;
    if (rst_n) begin
      lus = HAZ && id_if.IdValid && m_valid[0] && m_ctrl[0][OFF_MEM_READ] && (m_rd[0] != 0)
            && (m_rd[0] == id_if.IdRs1 || m_rd[0] == id_if.IdRs2) && !Flush;
      rdy = id_if.IdValid && !StallIn && !lus;
    end
    check_eq("IdReady", id_if.IdReady, rdy);
    check_eq("LoadUseStall", LoadUseStall, lus);
    m_last_rdy = rdy;
    if (!rst_n) begin
      model_reset();
    end else if (!StallIn) begin
      if (m_valid[2]) m_retire = m_retire + 32'd1;
      for (int i = 2; i > 0; i--) begin
        m_valid[i] = m_valid[i-1];
        m_ctrl[i]  = m_ctrl[i-1];
        m_rd[i]    = m_rd[i-1];
      end
      if (rdy && !Flush) begin
        w = id_if.IdCtrl;
        if (id_if.IdRd == 5'd0) w[OFF_REG_WRITE] = 1'b0;
        m_valid[0] = 1'b1;
        m_ctrl[0]  = w;
        m_rd[0]    = id_if.IdRd;
      end else begin
        m_valid[0] = 1'b0;
        m_ctrl[0]  = bubble_word();
        m_rd[0]    = 5'd0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    check_eq("ExValid", ExValid, m_valid[0]);
    check_eq("ExCtrl", ExCtrl, m_ctrl[0]);
    check_eq("ExRd", ExRd, m_rd[0]);
    check_eq("MemValid", MemValid, m_valid[1]);
    check_eq("MemCtrl", MemCtrl, m_ctrl[1][MEM_CTRL_WIDTH-1:0]);
    check_eq("MemRd", MemRd, m_rd[1]);
    check_eq("WbValid", WbValid, m_valid[2]);
    check_eq("WbCtrl", WbCtrl, m_ctrl[2][WB_CTRL_WIDTH-1:0]);
    check_eq("WbRd", WbRd, m_rd[2]);
    check_eq("RetireCount", RetireCount, m_retire);
    $display("cyc %0d rst_n=%b stall=%b flush=%b rdy=%b lus=%b ex=%b/%0d mem=%b/%0d wb=%b/%0d ret=%0h",
             cyc, rst_n, StallIn, Flush, rdy, lus, ExValid, ExRd, MemValid, MemRd,
             WbValid, WbRd, RetireCount);
  endtask

  // Present one word until the model says it is consumed (bounded), then idle.
  task automatic issue(input logic [CTRL_WIDTH-1:0] c, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    drive(1'b1, c, rd, rs1, rs2);
    m_last_rdy = 1'b0;
    for (int k = 0; k < 4 && !m_last_rdy; k++) cycle();
    drive(1'b0, '0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    logic [CTRL_WIDTH-1:0] add_w, ld_w, br_w;
    add_w = mk_ctrl(1'b1, 1'b0, 1'b0, BRU_NOP, 4'd1, 1'b0);
    ld_w  = mk_ctrl(1'b1, 1'b1, 1'b0, BRU_NOP, 4'd0, 1'b0);
    br_w  = mk_ctrl(1'b0, 1'b0, 1'b0, 3'b001, 4'd2, 1'b1);
    drive(1'b0, '0, 5'd0, 5'd0, 5'd0);
    model_reset();

    // Reset state, with a valid word offered during reset.
    rst_n = 1'b0;
    drive(1'b1, add_w, 5'd3, 5'd1, 5'd2);
    idle(2);
    drive(1'b0, '0, 5'd0, 5'd0, 5'd0);
    rst_n = 1'b1;

    // Single add to WB after 3 advances, retire one cycle later.
    issue(add_w, 5'd5, 5'd1, 5'd2);
    idle(4);

    // Load followed by a dependent consumer.
    issue(ld_w, 5'd7, 5'd1, 5'd0);
    issue(add_w, 5'd8, 5'd7, 5'd3);
    idle(3);

    // Branch in EX, then Flush with a wrong-path word in ID.
    issue(br_w, 5'd1, 5'd2, 5'd3);
    drive(1'b1, add_w, 5'd9, 5'd4, 5'd5);
    Flush = 1'b1;
    cycle();
    Flush = 1'b0;
    drive(1'b0, '0, 5'd0, 5'd0, 5'd0);
    idle(3);

    // Full pipe held by StallIn for 4 cycles; Flush during stall is ignored.
    issue(add_w, 5'd10, 5'd1, 5'd1);
    issue(ld_w, 5'd11, 5'd2, 5'd2);
    issue(add_w, 5'd12, 5'd3, 5'd3);
    drive(1'b1, add_w, 5'd13, 5'd4, 5'd4);
    StallIn = 1'b1;
    cycle();
    Flush = 1'b1;
    cycle();
    Flush = 1'b0;
    idle(2);
    StallIn = 1'b0;
    drive(1'b0, '0, 5'd0, 5'd0, 5'd0);
    idle(1);

    // Write to x0 must lose RegWriteEn.
    issue(add_w, 5'd0, 5'd1, 5'd2);
    idle(4);

    // RetireCount wrap: preload while frozen, then retire one word.
    issue(add_w, 5'd14, 5'd1, 5'd1);
    issue(add_w, 5'd15, 5'd1, 5'd1);
    issue(add_w, 5'd16, 5'd1, 5'd1);
    StallIn = 1'b1;
    cycle();
    force dut.retire_q = 32'hFFFF_FFFF;
    m_retire = 32'hFFFF_FFFF;
    cycle();
    release dut.retire_q;
    cycle();
    StallIn = 1'b0;
    cycle();

    // Reset with a full pipe.
    issue(add_w, 5'd17, 5'd1, 5'd1);
    issue(add_w, 5'd18, 5'd1, 5'd1);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    idle(1);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      logic [CTRL_WIDTH-1:0] c;
      c = CTRL_WIDTH'($urandom);
      c[OFF_MEM_READ] = ($urandom_range(0, 2) == 0);
      rst_n   = ($urandom_range(0, 63) != 0);
      StallIn = ($urandom_range(0, 4) == 0);
      Flush   = ($urandom_range(0, 7) == 0);
      drive($urandom_range(0, 3) != 0, c, 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      cycle();
    end
    rst_n = 1'b1;
    StallIn = 1'b0;
    Flush = 1'b0;
    drive(1'b0, '0, 5'd0, 5'd0, 5'd0);
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
